// File: rtl/liang_pkg.sv
// Shared fetch-stage types and constants used by the IFU and its fetch queue.
package liang_pkg;

  typedef logic [31:0] pc_t;
  typedef logic [31:0] inst_t;

  typedef struct packed {
    pc_t   pc;
    inst_t inst;
  } ifToId_t;

  localparam pc_t IFU_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/pipe_ifu_fifo.sv
// Power-of-two circular fetch queue with synchronous clear and a registered
// head (no push-to-head bypass).
module pipe_ifu_fifo
  import liang_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = ifToId_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  input  logic                       clear,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] cnt,
  output T                           head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  T              mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign cnt   = count;
  assign head  = mem[rd_ptr];

  // A pop frees the slot the same cycle, so a full queue can still accept a push.
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pipe_ifu_fq.sv
// Fetch stage: sequential imem requests, in-order responses buffered in a fetch
// queue toward ID. Optional IFU_PERF_CNT_EN adds fetch/stall performance counters.
module pipe_ifu_fq
  import liang_pkg::*;
#(
  parameter pc_t RESET_PC  = IFU_RESET_PC,
  parameter int  FQ_DEPTH  = 4,
  parameter int  MAX_OUTST = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output ifToId_t     ifToId_o,
  output logic        if_valid_o,
  input  logic        id_ready_i
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_stall_o
`endif
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int SW = ((OW > CW) ? OW : CW) + 1;

  pc_t           fetch_pc;
  pc_t           rsp_pc;
  pc_t           flush_tgt;
  logic [OW-1:0] out_cnt;
  logic [OW-1:0] drop_cnt;
  logic [CW-1:0] fq_cnt;
  logic [SW-1:0] committed;
  logic          fq_full;
  logic          fq_empty;
  logic          can_issue;
  logic          req_fire;
  logic          rsp_fire;
  logic          rsp_drop;
  logic          fq_push;
  logic          fq_pop;
  ifToId_t       fq_wdata;
  logic          unused_pc_lsbs;

  assign flush_tgt      = {flush_pc_i[31:2], 2'b00};
  assign unused_pc_lsbs = ^flush_pc_i[1:0];

  // Slots already spoken for: queued entries plus live (non-stale) requests in flight.
  assign committed = SW'(fq_cnt) + SW'(out_cnt) - SW'(drop_cnt);
  assign can_issue = !flush_i && (out_cnt < OW'(MAX_OUTST)) &&
                     (committed < SW'(FQ_DEPTH));

  assign imem_req_valid_o = !rst_i && can_issue;
  assign imem_req_addr_o  = rst_i ? 32'h0 : fetch_pc;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  assign rsp_fire = imem_rsp_valid_i;
  assign rsp_drop = (drop_cnt != '0);
  assign fq_push  = rsp_fire && !rsp_drop && !flush_i && (!fq_full || fq_pop);
  assign fq_wdata = '{pc: rsp_pc, inst: imem_rsp_data_i};

  assign if_valid_o = !fq_empty;
  assign fq_pop     = if_valid_o && id_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else if (flush_i) begin
      // Everything still in flight after this cycle is stale and must be dropped.
      fetch_pc <= flush_tgt;
      rsp_pc   <= flush_tgt;
      out_cnt  <= out_cnt - OW'(rsp_fire);
      drop_cnt <= out_cnt - OW'(rsp_fire);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (rsp_fire && !rsp_drop) rsp_pc <= rsp_pc + 32'd4;
      if (rsp_fire && rsp_drop) drop_cnt <= drop_cnt - OW'(1);
      out_cnt <= out_cnt + OW'(req_fire) - OW'(rsp_fire);
    end
  end

  pipe_ifu_fifo #(
    .DEPTH (FQ_DEPTH),
    .T     (ifToId_t)
  ) u_fq (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (fq_push),
    .push_data (fq_wdata),
    .pop       (fq_pop),
    .clear     (flush_i),
    .full      (fq_full),
    .empty     (fq_empty),
    .cnt       (fq_cnt),
    .head      (ifToId_o)
  );

`ifdef IFU_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_fetch_o <= '0;
      perf_stall_o <= '0;
    end else begin
      perf_fetch_o <= sat_inc(perf_fetch_o, fq_pop && !flush_i);
      perf_stall_o <= sat_inc(perf_stall_o, imem_req_valid_o && !imem_req_ready_i);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ifu_fq.sv
// Bench for pipe_ifu_fq: imem responder plus a queue-level model of the fetch stream.
module tb_pipe_ifu_fq;
  import liang_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAX   = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  ifToId_t     ifToId_o;
  logic        if_valid_o;
  logic        id_ready_i = 1'b0;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_o;
  logic [31:0] perf_stall_o;
`endif

  pipe_ifu_fq dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .flush_pc_i       (flush_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .ifToId_o         (ifToId_o),
    .if_valid_o       (if_valid_o),
    .id_ready_i       (id_ready_i)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_o     (perf_fetch_o),
    .perf_stall_o     (perf_stall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    int          lat;
    logic [31:0] fpc;
    logic [31:0] first;
    logic [31:0] second;
  } fvec_t;

  req_t        infl[$];
  ifToId_t     fq[$];
  logic [31:0] plog[$];
  logic [31:0] mfetch;
  int          cyc, last_due, pop_cnt, dut_pops, stall_cnt;
  int          n_chk, n_fail;
  bit          rdy, idr;
  int          lat;
  fvec_t       vt[4];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (infl[i]) if (!infl[i].stale) n++;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, check settled outputs, advance the model across the posedge.
  task automatic step(input bit fl, input logic [31:0] fpc);
    bit     rsp_now, exp_v;
    req_t   e;
    int     d;
    flush_i          = fl;
    flush_pc_i       = fpc;
    imem_req_ready_i = rdy;
    id_ready_i       = idr;
    rsp_now          = (infl.size() != 0) && (infl[0].due <= cyc);
    imem_rsp_valid_i = rsp_now;
    imem_rsp_data_i  = rsp_now ? memf(infl[0].addr) : $urandom;
    #1;
    exp_v = !fl && (infl.size() < MAX) && ((fq.size() + live_cnt()) < DEPTH);
    chk("req_valid", imem_req_valid_o, exp_v);
    if (exp_v) chk("req_addr", imem_req_addr_o, mfetch);
    chk("if_valid", if_valid_o, fq.size() != 0);
    if (fq.size() != 0) begin
      chk("head_pc", ifToId_o.pc, fq[0].pc);
      chk("head_inst", ifToId_o.inst, fq[0].inst);
    end
    if (if_valid_o && idr && !fl) dut_pops++;
    if (exp_v && !rdy) stall_cnt++;
    if ((fq.size() != 0) && idr && !fl) begin
      plog.push_back(fq[0].pc);
      void'(fq.pop_front());
      pop_cnt++;
    end
    if (rsp_now) begin
      e = infl.pop_front();
      if (!e.stale && !fl) fq.push_back('{pc: e.addr, inst: memf(e.addr)});
    end
    if (exp_v && rdy) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      infl.push_back('{addr: mfetch, due: d, stale: 1'b0});
      mfetch = mfetch + 32'd4;
    end
    if (fl) begin
      fq.delete();
      foreach (infl[i]) infl[i].stale = 1'b1;
      mfetch = {fpc[31:2], 2'b00};
    end
    cyc++;
    @(negedge clk_i);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    int  base, need;
    bit  found;
    logic [31:0] held, snap;

    vt[0] = '{3, 32'h8000_1002, 32'h8000_1000, 32'h8000_1004};
    vt[1] = '{1, 32'h0000_0003, 32'h0000_0000, 32'h0000_0004};
    vt[2] = '{2, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
    vt[3] = '{3, 32'h1234_5679, 32'h1234_5678, 32'h1234_567C};

    n_chk = 0; n_fail = 0; cyc = 0; last_due = -1;
    pop_cnt = 0; dut_pops = 0; stall_cnt = 0;
    mfetch = IFU_RESET_PC;

    @(negedge clk_i); #1;
    chk("rst_req_valid", imem_req_valid_o, 0);
    chk("rst_req_addr", imem_req_addr_o, 0);
    chk("rst_if_valid", if_valid_o, 0);
`ifdef IFU_PERF_CNT_EN
    chk("rst_perf_fetch", perf_fetch_o, 0);
    chk("rst_perf_stall", perf_stall_o, 0);
`endif
    @(negedge clk_i);
    rst_i = 1'b0;

    // Streaming: one instruction per cycle once the pipe is filled.
    rdy = 1; idr = 1; lat = 1;
    for (int k = 0; k < 10; k++) step(0, 0);
    base = dut_pops;
    for (int k = 0; k < 20; k++) step(0, 0);
    chk("stream_rate", dut_pops - base, 20);
    for (int k = 0; k < 8; k++) chk("stream_pc", plog[k], IFU_RESET_PC + 32'(4 * k));

    // ID back-pressure: queue fills, requests stop, then drains in order.
    idr = 0;
    for (int k = 0; k < 12; k++) step(0, 0);
    chk("full_no_req", imem_req_valid_o, 0);
    chk("full_if_valid", if_valid_o, 1);
    rdy = 0; idr = 1; base = dut_pops;
    for (int k = 0; k < 8; k++) step(0, 0);
    chk("drain_count", dut_pops - base, 4);

    // imem stall: address held for 5 cycles, then resumes in order.
    rdy = 1;
    for (int k = 0; k < 6; k++) step(0, 0);
`ifdef IFU_PERF_CNT_EN
    snap = perf_stall_o;
`else
    snap = 0;
`endif
    held = mfetch;
    rdy = 0;
    for (int k = 0; k < 5; k++) step(0, 0);
    chk("stall_addr_held", imem_req_addr_o, held);
    chk("stall_valid_held", imem_req_valid_o, 1);
`ifdef IFU_PERF_CNT_EN
    chk("perf_stall_5", perf_stall_o - snap, 5);
    chk("perf_fetch_pops", perf_fetch_o, pop_cnt);
`endif
    rdy = 1;
    for (int k = 0; k < 10; k++) step(0, 0);

    // Redirects with requests in flight; stale responses must not reach ID.
    for (int v = 0; v < 4; v++) begin
      lat = vt[v].lat; rdy = 1; idr = 1;
      need = (vt[v].lat >= 2) ? 2 : 1;
      found = 0;
      for (int k = 0; k < 30; k++) begin
        if (infl.size() >= need) begin found = 1; break; end
        step(0, 0);
      end
      chk("flush_setup", found, 1);
      step(1, vt[v].fpc);
      chk("flush_next_addr", imem_req_addr_o, vt[v].first);
      base = plog.size();
      for (int k = 0; k < 30 && plog.size() < base + 2; k++) step(0, 0);
      chk("flush_first_pc", (plog.size() > base) ? plog[base] : 32'hDEAD_BEEF, vt[v].first);
      chk("flush_second_pc", (plog.size() > base + 1) ? plog[base + 1] : 32'hDEAD_BEEF,
          vt[v].second);
    end

    // Flush coinciding with a live response and a pop.
    step(1, 32'h9000_0000);
    lat = 2; idr = 0; rdy = 1; found = 0;
    for (int k = 0; k < 30; k++) begin
      if (infl.size() == 2 && infl[0].due <= cyc && fq.size() != 0) begin found = 1; break; end
      step(0, 0);
    end
    chk("flush_rsp_pop_setup", found, 1);
    idr = 1;
    step(1, 32'h9000_0100);
    chk("flush_fq_empty", if_valid_o, 0);
    base = plog.size();
    for (int k = 0; k < 30 && plog.size() <= base; k++) step(0, 0);
    chk("flush_rsp_first_pc", (plog.size() > base) ? plog[base] : 32'hDEAD_BEEF, 32'h9000_0100);

    // Randomized traffic with occasional redirects.
    for (int k = 0; k < 1500; k++) begin
      rdy = ($urandom_range(0, 3) != 0);
      idr = ($urandom_range(0, 2) != 0);
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 39) == 0) step(1, $urandom);
      else step(0, 0);
    end
`ifdef IFU_PERF_CNT_EN
    chk("perf_stall_total", perf_stall_o, stall_cnt);
    chk("perf_fetch_total", perf_fetch_o, pop_cnt);
`endif

    // Reset mid-run: outputs clear immediately and fetch restarts at the reset PC.
    imem_rsp_valid_i = 0; flush_i = 0;
    rst_i = 1'b1; #1;
    chk("midrst_req_valid", imem_req_valid_o, 0);
    chk("midrst_req_addr", imem_req_addr_o, 0);
    chk("midrst_if_valid", if_valid_o, 0);
    infl.delete(); fq.delete(); mfetch = IFU_RESET_PC; last_due = -1;
    @(negedge clk_i);
    rst_i = 1'b0;
    rdy = 1; idr = 1; lat = 1;
    base = plog.size();
    for (int k = 0; k < 10; k++) step(0, 0);
    chk("post_reset_pc", (plog.size() > base) ? plog[base] : 32'hDEAD_BEEF, IFU_RESET_PC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
